// File: rtl/oled_frame_streamer.sv
// Raster-scans an SSD1331 panel, fetches RGB565 pixels from a combinational
// generator and streams a window-address command burst plus pixel data over SPI.
module oled_frame_streamer #(
  parameter int CLK_DIV = 1,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_req,
  input  logic [15:0] pixel_data,
  output logic [6:0]  X,
  output logic [5:0]  Y,
  output logic        busy,
  output logic        frame_done,
  output logic        cs_n,
  output logic        dc,
  output logic        sclk,
  output logic        sdata
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PIX} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST   = 6'(HEIGHT - 1);

  state_t      r_state;
  logic [7:0]  r_div;
  logic [3:0]  r_bitCnt;
  logic [2:0]  r_byteIdx;
  logic [15:0] r_shift;
  logic [15:0] r_hold;
  logic        r_fetch;
  logic        r_lastPix;
  logic [6:0]  r_X;
  logic [5:0]  r_Y;
  logic        r_busy;
  logic        r_frameDone;
  logic        r_csN;
  logic        r_dc;
  logic        r_sclk;
  logic        r_sdata;

  logic [2:0]  w_nextIdx;
  logic [7:0]  w_cmdByte;
  logic        w_atLast;
  logic [6:0]  w_nextX;
  logic [5:0]  w_nextY;

  assign w_nextIdx = r_byteIdx + 3'd1;
  assign w_atLast  = (r_X == X_LAST) && (r_Y == Y_LAST);
  assign w_nextX   = (r_X == X_LAST) ? 7'd0 : r_X + 7'd1;
  assign w_nextY   = (r_X != X_LAST) ? r_Y : ((r_Y == Y_LAST) ? 6'd0 : r_Y + 6'd1);

  // Column/row window command bytes; byte 0 (0x15) is loaded directly on accept.
  always_comb begin
    w_cmdByte = 8'h15;
    case (w_nextIdx)
      3'd1:    w_cmdByte = 8'h00;
      3'd2:    w_cmdByte = 8'(WIDTH - 1);
      3'd3:    w_cmdByte = 8'h75;
      3'd4:    w_cmdByte = 8'h00;
      3'd5:    w_cmdByte = 8'(HEIGHT - 1);
      default: w_cmdByte = 8'h15;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_bitCnt    <= 4'd0;
      r_byteIdx   <= 3'd0;
      r_shift     <= 16'd0;
      r_hold      <= 16'd0;
      r_fetch     <= 1'b0;
      r_lastPix   <= 1'b0;
      r_X         <= 7'd0;
      r_Y         <= 6'd0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_csN       <= 1'b1;
      r_dc        <= 1'b0;
      r_sclk      <= 1'b1;
      r_sdata     <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      // Generator has one cycle of latency after X/Y move.
      if (r_fetch) begin
        r_hold  <= pixel_data;
        r_fetch <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_req) begin
            r_state   <= S_CMD;
            r_busy    <= 1'b1;
            r_csN     <= 1'b0;
            r_dc      <= 1'b0;
            r_sclk    <= 1'b0;
            r_div     <= 8'd0;
            r_bitCnt  <= 4'd0;
            r_byteIdx <= 3'd0;
            r_sdata   <= 1'b0;
            r_shift   <= {7'h15, 9'd0};
            r_X       <= 7'd0;
            r_Y       <= 6'd0;
            r_fetch   <= 1'b1;
            r_lastPix <= 1'b0;
          end
        end
        default: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bitCnt != ((r_state == S_CMD) ? 4'd7 : 4'd15)) begin
                r_bitCnt <= r_bitCnt + 4'd1;
                r_sdata  <= r_shift[15];
                r_shift  <= {r_shift[14:0], 1'b0};
              end else if (r_state == S_CMD && r_byteIdx != 3'd5) begin
                r_byteIdx <= w_nextIdx;
                r_bitCnt  <= 4'd0;
                r_sdata   <= w_cmdByte[7];
                r_shift   <= {w_cmdByte[6:0], 9'd0};
              end else if (r_state == S_PIX && r_lastPix) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_csN       <= 1'b1;
                r_sclk      <= 1'b1;
                r_dc        <= 1'b0;
                r_sdata     <= 1'b0;
                r_bitCnt    <= 4'd0;
                r_frameDone <= 1'b1;
                r_X         <= 7'd0;
                r_Y         <= 6'd0;
              end else begin
                // Start of a pixel MSB: load captured colour and move X/Y on.
                r_state   <= S_PIX;
                r_dc      <= 1'b1;
                r_bitCnt  <= 4'd0;
                r_sdata   <= r_hold[15];
                r_shift   <= {r_hold[14:0], 1'b0};
                r_lastPix <= w_atLast;
                r_X       <= w_nextX;
                r_Y       <= w_nextY;
                r_fetch   <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign X          = r_X;
  assign Y          = r_Y;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;
  assign cs_n       = r_csN;
  assign dc         = r_dc;
  assign sclk       = r_sclk;
  assign sdata      = r_sdata;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench: an 8x4 panel at CLK_DIV=1 for stream/timing checks and a
// second 8x4 instance at CLK_DIV=3 for the abort and divider checks.
module tb_oled_frame_streamer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int FRAME_BITS = 48 + 16 * W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn0 = 1'b0;
  logic        frameReq0 = 1'b0;
  logic [15:0] pix0;
  logic [6:0]  x0;
  logic [5:0]  y0;
  logic        busy0, done0, cs0, dc0, sclk0, sdata0;

  logic        rstn1 = 1'b0;
  logic        frameReq1 = 1'b0;
  logic [15:0] pix1;
  logic [6:0]  x1;
  logic [5:0]  y1;
  logic        busy1, done1, cs1, dc1, sclk1, sdata1;

  assign pix0 = {x0[4:0], y0, x0[4:0]};
  assign pix1 = {x1[4:0], y1, x1[4:0]};

  oled_frame_streamer #(.CLK_DIV(1), .WIDTH(W), .HEIGHT(H)) u_dut (
    .clk(clk), .rstn(rstn0), .frame_req(frameReq0), .pixel_data(pix0),
    .X(x0), .Y(y0), .busy(busy0), .frame_done(done0),
    .cs_n(cs0), .dc(dc0), .sclk(sclk0), .sdata(sdata0)
  );

  oled_frame_streamer #(.CLK_DIV(3), .WIDTH(W), .HEIGHT(H)) u_dutDiv3 (
    .clk(clk), .rstn(rstn1), .frame_req(frameReq1), .pixel_data(pix1),
    .X(x1), .Y(y1), .busy(busy1), .frame_done(done1),
    .cs_n(cs1), .dc(dc1), .sclk(sclk1), .sdata(sdata1)
  );

  int nChecks = 0;
  int nPass = 0;

  logic capData [0:1023];
  logic capDc   [0:1023];
  int   capN, busyCycles, sclkRises, csGlitch;
  logic doneSeen, doneCsOk, timedOut;

  function automatic logic [15:0] expPix(input int n);
    logic [6:0] ex;
    logic [5:0] ey;
    ex = 7'(n % W);
    ey = 6'(n / W);
    return {ex[4:0], ey, ex[4:0]};
  endfunction

  function automatic logic [15:0] capWord(input int start, input int len);
    logic [15:0] w;
    w = 16'd0;
    for (int i = 0; i < len; i++) w = {w[14:0], capData[start + i]};
    return w;
  endfunction

  task automatic startFrame0();
    @(negedge clk);
    frameReq0 = 1'b1;
    @(posedge clk);
    #1 frameReq0 = 1'b0;
  endtask

  // Samples DUT0 each negedge until frame_done; optionally pulses frame_req mid-frame.
  task automatic captureFrame(input int budget, input int pulseAt);
    logic prev;
    prev = 1'b0;
    capN = 0; busyCycles = 0; sclkRises = 0; csGlitch = 0;
    doneSeen = 1'b0; doneCsOk = 1'b0; timedOut = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pulseAt >= 0 && c == pulseAt) frameReq0 = 1'b1;
      if (pulseAt >= 0 && c == pulseAt + 2) frameReq0 = 1'b0;
      if (busy0 === 1'b1) busyCycles++;
      if (cs0 !== ~busy0) csGlitch++;
      if (prev == 1'b0 && sclk0 === 1'b1 && busy0 === 1'b1) begin
        if (capN < 1024) begin
          capData[capN] = sdata0;
          capDc[capN] = dc0;
        end
        capN++;
        sclkRises++;
      end
      prev = sclk0;
      if (done0 === 1'b1) begin
        doneSeen = 1'b1;
        doneCsOk = (cs0 === 1'b1) && (busy0 === 1'b0) && (dc0 === 1'b0) && (sclk0 === 1'b1);
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int doneCnt;
    doneCnt = 0;
    rstn0 = 1'b0; rstn1 = 1'b0; frameReq0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) doneCnt++;
    end
    nChecks++; if (busy0 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy0); else nPass++;
    nChecks++; if (cs0 !== 1'b1) $display("[TB] FAIL reset_cs_n: got %b expected 1", cs0); else nPass++;
    nChecks++; if (sclk0 !== 1'b1) $display("[TB] FAIL reset_sclk: got %b expected 1", sclk0); else nPass++;
    nChecks++; if (x0 !== 7'd0) $display("[TB] FAIL reset_X: got %0d expected 0", x0); else nPass++;
    nChecks++; if (y0 !== 6'd0) $display("[TB] FAIL reset_Y: got %0d expected 0", y0); else nPass++;
    nChecks++; if (dc0 !== 1'b0) $display("[TB] FAIL reset_dc: got %b expected 0", dc0); else nPass++;
    nChecks++; if (sdata0 !== 1'b0) $display("[TB] FAIL reset_sdata: got %b expected 0", sdata0); else nPass++;
    nChecks++; if (doneCnt != 0) $display("[TB] FAIL reset_frame_done: got %0d pulses expected 0", doneCnt); else nPass++;
    frameReq0 = 1'b0;
    @(negedge clk);
    rstn0 = 1'b1; rstn1 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_command_burst();
    logic [7:0] expBytes [0:5];
    logic [7:0] got;
    int dcOnes;
    expBytes[0] = 8'h15; expBytes[1] = 8'h00; expBytes[2] = 8'h07;
    expBytes[3] = 8'h75; expBytes[4] = 8'h00; expBytes[5] = 8'h03;
    startFrame0();
    captureFrame(3000, -1);
    nChecks++; if (timedOut) $display("[TB] FAIL cmd_frame_timeout: got no frame_done expected one within 3000 cycles"); else nPass++;
    for (int b = 0; b < 6; b++) begin
      got = 8'(capWord(8 * b, 8));
      nChecks++;
      if (got !== expBytes[b]) $display("[TB] FAIL cmd_byte%0d: got %02h expected %02h", b, got, expBytes[b]);
      else nPass++;
    end
    dcOnes = 0;
    for (int i = 0; i < 48; i++) if (capDc[i] !== 1'b0) dcOnes++;
    nChecks++; if (dcOnes != 0) $display("[TB] FAIL cmd_dc_low: got %0d command bits with dc!=0 expected 0", dcOnes); else nPass++;
    nChecks++; if (capDc[48] !== 1'b1) $display("[TB] FAIL cmd_dc_bit48: got %b expected 1", capDc[48]); else nPass++;
    nChecks++; if (csGlitch != 0) $display("[TB] FAIL cmd_cs_steady: got %0d cs_n glitches expected 0", csGlitch); else nPass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pixel_order();
    int bad;
    logic [15:0] got;
    startFrame0();
    captureFrame(3000, -1);
    nChecks++; if (timedOut) $display("[TB] FAIL pix_frame_timeout: got no frame_done expected one within 3000 cycles"); else nPass++;
    got = capWord(48 + 16 * 0, 16);
    nChecks++; if (got !== 16'h0000) $display("[TB] FAIL pix0: got %04h expected 0000", got); else nPass++;
    got = capWord(48 + 16 * 7, 16);
    nChecks++; if (got !== 16'h3807) $display("[TB] FAIL pix7: got %04h expected 3807", got); else nPass++;
    got = capWord(48 + 16 * 8, 16);
    nChecks++; if (got !== 16'h0020) $display("[TB] FAIL pix8: got %04h expected 0020", got); else nPass++;
    got = capWord(48 + 16 * 31, 16);
    nChecks++; if (got !== 16'h3867) $display("[TB] FAIL pix31: got %04h expected 3867", got); else nPass++;
    bad = 0;
    for (int n = 0; n < W * H; n++) if (capWord(48 + 16 * n, 16) !== expPix(n)) bad++;
    nChecks++; if (bad != 0) $display("[TB] FAIL pix_sweep: got %0d wrong pixels expected 0", bad); else nPass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_length();
    startFrame0();
    captureFrame(3000, -1);
    nChecks++; if (busyCycles != 2 * FRAME_BITS) $display("[TB] FAIL len_busy: got %0d expected %0d", busyCycles, 2 * FRAME_BITS); else nPass++;
    nChecks++; if (sclkRises != FRAME_BITS) $display("[TB] FAIL len_sclk_rises: got %0d expected %0d", sclkRises, FRAME_BITS); else nPass++;
    nChecks++; if (doneSeen !== 1'b1) $display("[TB] FAIL len_done_seen: got %b expected 1", doneSeen); else nPass++;
    nChecks++; if (doneCsOk !== 1'b1) $display("[TB] FAIL len_done_outputs: got %b expected 1 (cs_n=1 busy=0 dc=0 sclk=1)", doneCsOk); else nPass++;
    @(negedge clk);
    nChecks++; if (done0 !== 1'b0) $display("[TB] FAIL len_done_single: got %b expected 0", done0); else nPass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int gap, idleBusy;
    @(negedge clk);
    frameReq0 = 1'b1;
    @(posedge clk);
    captureFrame(3000, -1);
    nChecks++; if (timedOut) $display("[TB] FAIL b2b_first_timeout: got no frame_done expected one"); else nPass++;
    gap = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cs0 === 1'b1) gap++;
      else break;
    end
    nChecks++; if (gap != 1) $display("[TB] FAIL b2b_gap: got %0d cycles cs_n high expected 1", gap); else nPass++;
    nChecks++; if (busy0 !== 1'b1) $display("[TB] FAIL b2b_restart_busy: got %b expected 1", busy0); else nPass++;
    frameReq0 = 1'b0;
    captureFrame(3000, 300);
    nChecks++; if (busyCycles + 1 != 2 * FRAME_BITS) $display("[TB] FAIL b2b_second_len: got %0d expected %0d", busyCycles + 1, 2 * FRAME_BITS); else nPass++;
    nChecks++; if (doneSeen !== 1'b1) $display("[TB] FAIL b2b_second_done: got %b expected 1", doneSeen); else nPass++;
    idleBusy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy0 !== 1'b0) idleBusy++;
    end
    nChecks++; if (idleBusy != 0) $display("[TB] FAIL b2b_pulse_not_queued: got %0d busy cycles expected 0", idleBusy); else nPass++;
  endtask

  task automatic test_abort_divider();
    int rises, lowCnt, highCnt, phase, nb, doneCnt;
    logic prev;
    logic [7:0] b;
    @(negedge clk);
    frameReq1 = 1'b1;
    @(posedge clk);
    #1 frameReq1 = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 5000 && rises < 370; c++) begin
      @(negedge clk);
      if (prev == 1'b0 && sclk1 === 1'b1) rises++;
      prev = sclk1;
    end
    nChecks++; if (rises < 370) $display("[TB] FAIL abort_reach_pixel20: got %0d rises expected 370", rises); else nPass++;
    nChecks++; if (dc1 !== 1'b1) $display("[TB] FAIL abort_in_pix: got dc=%b expected 1", dc1); else nPass++;
    @(negedge clk);
    rstn1 = 1'b0;
    #1;
    nChecks++; if (cs1 !== 1'b1 || sclk1 !== 1'b1) $display("[TB] FAIL abort_async: got cs_n=%b sclk=%b expected 1 1", cs1, sclk1); else nPass++;
    nChecks++; if (busy1 !== 1'b0 || dc1 !== 1'b0 || sdata1 !== 1'b0) $display("[TB] FAIL abort_outputs: got busy=%b dc=%b sdata=%b expected 0 0 0", busy1, dc1, sdata1); else nPass++;
    nChecks++; if (x1 !== 7'd0 || y1 !== 6'd0) $display("[TB] FAIL abort_xy: got %0d,%0d expected 0,0", x1, y1); else nPass++;
    doneCnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) doneCnt++;
    end
    nChecks++; if (doneCnt != 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneCnt); else nPass++;
    rstn1 = 1'b1;
    repeat (2) @(negedge clk);
    frameReq1 = 1'b1;
    @(posedge clk);
    #1 frameReq1 = 1'b0;
    lowCnt = 0; highCnt = 0; phase = 0; nb = 0; b = 8'd0; prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (prev == 1'b0 && sclk1 === 1'b1 && nb < 8) begin
        b = {b[6:0], sdata1};
        nb++;
      end
      if (phase == 0) begin
        if (sclk1 === 1'b0) lowCnt++;
        else begin phase = 1; highCnt = 1; end
      end else if (phase == 1) begin
        if (sclk1 === 1'b1) highCnt++;
        else phase = 2;
      end
      prev = sclk1;
      if (nb == 8 && phase == 2) break;
    end
    nChecks++; if (b !== 8'h15) $display("[TB] FAIL div3_first_byte: got %02h expected 15", b); else nPass++;
    nChecks++; if (lowCnt != 3) $display("[TB] FAIL div3_low_half: got %0d expected 3", lowCnt); else nPass++;
    nChecks++; if (highCnt != 3) $display("[TB] FAIL div3_high_half: got %0d expected 3", highCnt); else nPass++;
    nChecks++; if (cs1 !== 1'b0 || dc1 !== 1'b0) $display("[TB] FAIL div3_cmd_lines: got cs_n=%b dc=%b expected 0 0", cs1, dc1); else nPass++;
  endtask

  initial begin
    test_reset();
    test_command_burst();
    test_pixel_order();
    test_frame_length();
    test_back_to_back();
    test_abort_divider();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Consumer end of the pixel interface that the stadium/sprite generators drive.
- Scans the 96x64 SSD1331 panel in raster order and presents X/Y coordinates to a combinational pixel generator.
- Captures the returned 16-bit RGB565 colour and serialises it, MSB first, over the 4-wire SPI link to the OLED.
- Each frame is preceded by a 6-byte window-address command burst.

Parameters:
CLK_DIV, 1, clk cycles per SPI half-bit; one bit period is 2*CLK_DIV clk cycles; legal values 1..255
WIDTH, 96, panel columns; X range 0..WIDTH-1
HEIGHT, 64, panel rows; Y range 0..HEIGHT-1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
frame_req  in  1  start request, sampled on rising clk
pixel_data  in  16  RGB565 colour for current X/Y, combinational from the generator
X  out  7  column being requested
Y  out  6  row being requested
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse at end of frame
cs_n  out  1  SPI chip select, active low
dc  out  1  0 = command byte, 1 = pixel data
sclk  out  1  SPI clock, idle high
sdata  out  1  SPI data

Behaviour:
- Reset values: state IDLE; X=0, Y=0; busy=0, frame_done=0, cs_n=1, dc=0, sclk=1, sdata=0.
- Reset asserted mid-frame aborts the frame immediately: cs_n=1 and sclk=1 asynchronously; no frame_done is issued.
- States: IDLE, CMD, PIX.
- IDLE -> CMD: on a clk edge with frame_req=1. This edge is the accept edge. On it: busy=1, cs_n=0, dc=0, bit period 0 begins, X/Y=(0,0).
- frame_req while busy=1 is ignored; it is not queued.
- Bit periods are contiguous.
- Each bit period: sdata updates at its start; sclk=0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles. The panel samples on the sclk rising edge.
- CMD sends bytes 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1 (defaults 0x15 00 5F 75 00 3F), MSB first, 48 bits, dc=0.
- CMD -> PIX: on the edge starting bit 48; dc becomes 1 on that edge.
- PIX sends WIDTH*HEIGHT pixels, 16 bits each, MSB first. Order is row-major, X fastest.
- Pixel fetch, 1-cycle generator latency:
  - A holding register captures pixel_data on the clk edge one cycle after X/Y change.
  - At the start of each pixel's MSB bit period, the shift register loads from the holding register.
  - On that same edge X/Y advance to the next pixel.
  - X wraps WIDTH-1 -> 0 with Y incrementing; (WIDTH-1, HEIGHT-1) wraps to (0,0).
  - The first pixel (0,0) is captured during CMD.
- End of frame, on the edge ending the last pixel's LSB period:
  - state IDLE; busy=0, cs_n=1, sclk=1, dc=0.
  - frame_done=1 for exactly one cycle.
  - X/Y=(0,0).
- Frame length: busy is high for exactly 2*CLK_DIV*(48 + 16*WIDTH*HEIGHT) cycles. Defaults: 196704 cycles with CLK_DIV=1.
- frame_req high on the frame_done cycle starts a new frame on the next edge; there is no extra gap.
- cs_n stays low for the entire frame; it never toggles between bytes.
- Counters: bit counter 4 bits; command byte index 3 bits; divider 8 bits; all wrap modulo their terminal value with no overflow.

Test Plan:
1. Reset: hold rstn=0 with frame_req=1 for 10 cycles -> busy=0, cs_n=1, sclk=1, X=0, Y=0, frame_done never pulses.
2. Command burst (CLK_DIV=1): pulse frame_req -> bits sampled on sclk rising edges with dc=0 read 0x15,0x00,0x5F,0x75,0x00,0x3F; dc rises exactly at bit 48; cs_n low throughout.
3. Pixel order and latency: generator returns {X[4:0],Y,X[4:0]} -> pixel n in stream equals the value for (n mod 96, n div 96); pixels 0, 95, 96 and 6143 are checked explicitly.
4. Frame length (CLK_DIV=1): busy high exactly 196704 cycles; frame_done single pulse; cs_n rises on the same edge; 98352 sclk rising edges counted.
5. Request handling: frame_req held high continuously -> frames back-to-back with cs_n high for exactly one cycle between them. A frame_req pulse mid-frame has no effect on timing.
6. Abort and divider: CLK_DIV=3, drop rstn at pixel 100 then release -> outputs return to reset values instantly. The next frame_req restarts with 0x15, and sclk half-period is 3 cycles.
